data_checker: RTL and testbench
===============================

# data_checker

Receive-side checker for the error-correction channel test bench. It drains two bit-serial FIFOs one bit per transaction: the reference stream written by the data generator, and the stream recovered after the channel/decoder. It compares the two bitwise over a fixed number of bits, counts mismatches, and signals DONE with a PASS/FAIL verdict. It sits at the output end of the channel, opposite the generator, and reads its FIFOs the same way the generator writes its own.

## Interface
- BITS_NUMB, 10: number of bits compared per run; must be ≥1.
- MAX_ERRORS, 0: largest mismatch count that still yields PASS.
- TIMEOUT_CYCLES, 1000: stall-cycle limit; used only with DATA_CHECKER_TIMEOUT_EN.
- CLK  input  1  single clock; all logic on rising edge.
- RESETN  input  1  synchronous reset, active-low.
- START  input  1  begin a run; sampled only in INIT.
- FIFO_REF_DATA  input  1  reference bit, valid the cycle after FIFO_REF_RE.
- FIFO_REF_EMPTY  input  1  reference FIFO empty.
- FIFO_REF_RE  output  1  reference FIFO read enable.
- FIFO_IN_DATA  input  1  received bit, valid the cycle after FIFO_IN_RE.
- FIFO_IN_EMPTY  input  1  received FIFO empty.
- FIFO_IN_RE  output  1  received FIFO read enable.
- ERR_COUNT  output  $clog2(BITS_NUMB+1)  registered mismatch count.
- DONE  output  1  registered; high from the end of REPORT until reset.
- PASS  output  1  registered; valid when DONE=1.
- TIMEOUT  output  1  registered; run aborted on stall.

## Operation
- FSM states, 3-bit encoding:
  - INIT
  - CHECK_FIFO_IN
  - READ_DATA
  - COMPARE
  - REPORT
  - IDLE
  - Any other encoding goes to INIT and triggers $error.
- INIT: on START=1, go to CHECK_FIFO_IN. Otherwise stay in INIT.
- CHECK_FIFO_IN:
  - If both EMPTY inputs are 0, go to READ_DATA.
  - Otherwise stay. RE is never asserted while the corresponding EMPTY=1.
- READ_DATA: FIFO_REF_RE=FIFO_IN_RE=1 for exactly this one cycle, then go to COMPARE.
- COMPARE:
  - Sample both DATA inputs.
  - If they differ, ERR_COUNT += 1.
  - Bit counter (width $clog2(BITS_NUMB), or 1 if BITS_NUMB=1) += 1.
  - If the counter was BITS_NUMB-1, clear it and go to REPORT. Otherwise go to CHECK_FIFO_IN.
- REPORT:
  - Set DONE=1 and PASS=(ERR_COUNT≤MAX_ERRORS)&&!TIMEOUT.
  - $display the bit count, ERR_COUNT, and time.
  - Go to IDLE.
- IDLE: terminal. RE stays 0. DONE, PASS and ERR_COUNT are held.
- Both RE outputs are combinational decodes of state (READ_DATA only). All other outputs are registered.
- ERR_COUNT cannot overflow: its maximum is BITS_NUMB.
- Reset values, applied when RESETN=0 at a rising edge:
  - state=INIT; bit counter=0; stall counter=0.
  - ERR_COUNT=0, DONE=0, PASS=0, TIMEOUT=0.
  - FIFO_REF_RE=FIFO_IN_RE=0.
- Reset mid-run behaves identically to power-up reset. The FIFOs are not flushed; that is the bench's responsibility.

## Timing
- 3 cycles per bit with no stall: CHECK → READ → COMPARE.
- FIFO read latency is 1 cycle; a first-word-fall-through FIFO is not supported.
- Edge where START is sampled = edge 0. With both FIFOs pre-filled:
  - The last COMPARE exits at edge 3·BITS_NUMB.
  - DONE rises at edge 3·BITS_NUMB+1.
- A stall adds exactly one cycle per CHECK_FIFO_IN cycle in which either FIFO is empty.
- START asserted outside INIT is ignored. It has no effect in IDLE; re-arming requires reset.

## Configuration
- Macro: DATA_CHECKER_TIMEOUT_EN.
- Defined:
  - A stall counter increments on each CHECK_FIFO_IN cycle with either EMPTY=1, and clears on leaving CHECK_FIFO_IN.
  - When it reaches TIMEOUT_CYCLES-1 while still stalled: set TIMEOUT=1, go to REPORT (so PASS=0), and $display "timeout".
  - ERR_COUNT keeps the mismatches counted so far.
- Undefined: no stall counter; TIMEOUT is tied to 0; CHECK_FIFO_IN waits indefinitely.

## Test plan
- Clean run: BITS_NUMB=10, both FIFOs hold identical 10-bit patterns, START pulse.
  - DONE rises at edge 31; ERR_COUNT=0; PASS=1; exactly 10 RE pulses on each FIFO.
- Injected errors: received stream has bits 3 and 7 inverted.
  - MAX_ERRORS=0: ERR_COUNT=2, PASS=0.
  - Rerun with MAX_ERRORS=2: PASS=1.
- Stall: received FIFO empty for 5 cycles before bit 4.
  - No RE while EMPTY=1; DONE at edge 36; ERR_COUNT=0.
- Timeout (macro on, TIMEOUT_CYCLES=16): received FIFO supplies only 4 bits.
  - TIMEOUT=1, DONE=1, PASS=0, ERR_COUNT=0, exactly 4 RE pulses.
- Same 4-bit scenario with the macro off:
  - FSM stays in CHECK_FIFO_IN; DONE=0; TIMEOUT=0.
- Reset mid-run: RESETN=0 for 1 cycle after 5 bits compared.
  - All outputs 0; no RE until START.
  - A new clean run completes at edge 31 with ERR_COUNT=0.

Source files
------------

// File: rtl/data_checker_if.sv
// Purpose : bundles the two bit-serial FIFO read ports (reference + received) seen by data_checker.
// Ports   : per FIFO, DATA (bit, valid the cycle after RE), EMPTY and RE.
// Modports: master = checker side (drives RE), slave = FIFO side (drives DATA/EMPTY).
interface data_checker_if;
    logic FIFO_REF_DATA;
    logic FIFO_REF_EMPTY;
    logic FIFO_REF_RE;
    logic FIFO_IN_DATA;
    logic FIFO_IN_EMPTY;
    logic FIFO_IN_RE;

    modport master (
        input  FIFO_REF_DATA,
        input  FIFO_REF_EMPTY,
        output FIFO_REF_RE,
        input  FIFO_IN_DATA,
        input  FIFO_IN_EMPTY,
        output FIFO_IN_RE
    );

    modport slave (
        output FIFO_REF_DATA,
        output FIFO_REF_EMPTY,
        input  FIFO_REF_RE,
        output FIFO_IN_DATA,
        output FIFO_IN_EMPTY,
        input  FIFO_IN_RE
    );
endinterface

// File: rtl/data_checker.sv
// Purpose : drains a reference and a received bit FIFO one bit at a time, counts mismatches over
//           BITS_NUMB bits and reports DONE with a PASS/FAIL verdict.
// Latency : 3 cycles per bit without stalls (check -> read -> compare); DONE one cycle after the last compare.
// Backpr. : waits in CHECK_FIFO_IN while either FIFO is empty; RE is never raised on an empty FIFO.
// Ports   : CLK, RESETN (sync, active-low), START, fifo (data_checker_if.master),
//           ERR_COUNT, DONE, PASS, TIMEOUT (all registered).
// Option  : DATA_CHECKER_TIMEOUT_EN enables the stall watchdog (TIMEOUT_CYCLES); otherwise TIMEOUT is 0.
module data_checker #(
    parameter int BITS_NUMB      = 10,
    parameter int MAX_ERRORS     = 0,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int ERR_W         = $clog2(BITS_NUMB + 1)
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 START,
    data_checker_if.master       fifo,
    output logic [ERR_W-1:0]     ERR_COUNT,
    output logic                 DONE,
    output logic                 PASS,
    output logic                 TIMEOUT
);
    localparam int CNT_W = (BITS_NUMB > 1) ? $clog2(BITS_NUMB) : 1;

    typedef enum logic [2:0] {
        INIT          = 3'd0,
        CHECK_FIFO_IN = 3'd1,
        READ_DATA     = 3'd2,
        COMPARE       = 3'd3,
        REPORT        = 3'd4,
        IDLE          = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               timeout_q;
    logic               stalled;

`ifdef DATA_CHECKER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic               timeout_d;
`else
    assign timeout_q = 1'b0;
`endif

    assign stalled = fifo.FIFO_REF_EMPTY || fifo.FIFO_IN_EMPTY;

    // Read enables are a pure decode of the READ_DATA state, so they can never
    // fire on an empty FIFO: READ_DATA is only entered after both were non-empty.
    assign fifo.FIFO_REF_RE = (state_q == READ_DATA);
    assign fifo.FIFO_IN_RE  = (state_q == READ_DATA);

    assign ERR_COUNT = err_count_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign TIMEOUT   = timeout_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        err_count_d = err_count_q;
        done_d      = done_q;
        pass_d      = pass_q;
`ifdef DATA_CHECKER_TIMEOUT_EN
        stall_cnt_d = '0;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            INIT: begin
                if (START) begin
                    state_d = CHECK_FIFO_IN;
                end
            end
            CHECK_FIFO_IN: begin
                if (!stalled) begin
                    state_d = READ_DATA;
                end else begin
`ifdef DATA_CHECKER_TIMEOUT_EN
                    // Abort once the stall has lasted TIMEOUT_CYCLES checks;
                    // mismatches counted so far are kept for the report.
                    if (stall_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = REPORT;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
`endif
                end
            end
            READ_DATA: begin
                state_d = COMPARE;
            end
            COMPARE: begin
                // DATA is valid now: one cycle after the RE pulse in READ_DATA.
                if (fifo.FIFO_REF_DATA != fifo.FIFO_IN_DATA) begin
                    err_count_d = err_count_q + 1'b1;
                end
                if (bit_cnt_q == CNT_W'(BITS_NUMB - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = REPORT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = CHECK_FIFO_IN;
                end
            end
            REPORT: begin
                done_d  = 1'b1;
                pass_d  = (32'(err_count_q) <= MAX_ERRORS) && !timeout_q;
                state_d = IDLE;
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q     <= INIT;
            bit_cnt_q   <= '0;
            err_count_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
`ifdef DATA_CHECKER_TIMEOUT_EN
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
`ifdef DATA_CHECKER_TIMEOUT_EN
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RESETN) begin
            if (state_q == REPORT) begin
                $display("data_checker: bits=%0d errors=%0d time=%0t",
                         timeout_q ? 32'(bit_cnt_q) : BITS_NUMB, err_count_q, $time);
            end
`ifdef DATA_CHECKER_TIMEOUT_EN
            if (timeout_d && !timeout_q) begin
                $display("data_checker: timeout at time %0t", $time);
            end
`endif
            if (state_q > IDLE) begin
                $error("data_checker: illegal state encoding %0d", state_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_checker.sv
// Purpose : directed bench for data_checker: clean run, injected errors, stall, short stream, mid-run reset.
// Latency : expects DONE at edge 3*BITS_NUMB+1 after the START edge, plus one edge per stalled check.
// Backpr. : FIFO models raise EMPTY from their pointers; the received FIFO can be held empty on demand.
module tb_data_checker;
    localparam int BN = 10;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESETN = 1'b0;
    logic       START  = 1'b0;
    logic [3:0] err0, err1;
    logic       done0, pass0, to0, done1, pass1, to1;

    data_checker_if fifo_if();
    data_checker_if fifo_if2();

    // Instance 0 tolerates no errors; instance 1 tolerates two. Both see the same FIFOs.
    data_checker #(.BITS_NUMB(BN), .MAX_ERRORS(0), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RESETN(RESETN), .START(START), .fifo(fifo_if),
        .ERR_COUNT(err0), .DONE(done0), .PASS(pass0), .TIMEOUT(to0));

    data_checker #(.BITS_NUMB(BN), .MAX_ERRORS(2), .TIMEOUT_CYCLES(16)) dut2 (
        .CLK(CLK), .RESETN(RESETN), .START(START), .fifo(fifo_if2),
        .ERR_COUNT(err1), .DONE(done1), .PASS(pass1), .TIMEOUT(to1));

    // FIFO models: one-cycle read latency, pointer-based empty flags.
    logic ref_mem [0:31];
    logic in_mem  [0:31];
    int   ref_wr = 0, in_wr = 0, ref_rd = 0, in_rd = 0;
    int   ref_pulses = 0, in_pulses = 0, re_viol = 0, re_diff = 0;
    logic hold_in = 1'b0;
    logic flush   = 1'b0;

    assign fifo_if.FIFO_REF_EMPTY  = (ref_rd == ref_wr);
    assign fifo_if.FIFO_IN_EMPTY   = (in_rd == in_wr) || hold_in;
    assign fifo_if2.FIFO_REF_EMPTY = fifo_if.FIFO_REF_EMPTY;
    assign fifo_if2.FIFO_IN_EMPTY  = fifo_if.FIFO_IN_EMPTY;
    assign fifo_if2.FIFO_REF_DATA  = fifo_if.FIFO_REF_DATA;
    assign fifo_if2.FIFO_IN_DATA   = fifo_if.FIFO_IN_DATA;

    always @(posedge CLK) begin
        if (flush) begin
            ref_rd     <= 0;
            in_rd      <= 0;
            ref_pulses <= 0;
            in_pulses  <= 0;
        end else begin
            re_viol <= re_viol + ((fifo_if.FIFO_REF_RE && fifo_if.FIFO_REF_EMPTY) ? 1 : 0)
                               + ((fifo_if.FIFO_IN_RE  && fifo_if.FIFO_IN_EMPTY)  ? 1 : 0);
            if ((fifo_if2.FIFO_REF_RE != fifo_if.FIFO_REF_RE) || (fifo_if2.FIFO_IN_RE != fifo_if.FIFO_IN_RE))
                re_diff <= re_diff + 1;
            if (fifo_if.FIFO_REF_RE) begin
                ref_pulses <= ref_pulses + 1;
                if (!fifo_if.FIFO_REF_EMPTY) begin
                    fifo_if.FIFO_REF_DATA <= ref_mem[ref_rd];
                    ref_rd <= ref_rd + 1;
                end
            end
            if (fifo_if.FIFO_IN_RE) begin
                in_pulses <= in_pulses + 1;
                if (!fifo_if.FIFO_IN_EMPTY) begin
                    fifo_if.FIFO_IN_DATA <= in_mem[in_rd];
                    in_rd <= in_rd + 1;
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Holds reset and flush for two edges while loading new FIFO contents.
    task automatic reset_and_load(input logic [9:0] r, input logic [9:0] d, input int n_in);
        RESETN  = 1'b0;
        flush   = 1'b1;
        hold_in = 1'b0;
        START   = 1'b0;
        for (int i = 0; i < BN; i++) ref_mem[i] = r[i];
        for (int i = 0; i < n_in; i++) in_mem[i] = d[i];
        ref_wr = BN;
        in_wr  = n_in;
        @(negedge CLK);
        @(negedge CLK);
        RESETN = 1'b1;
        flush  = 1'b0;
    endtask

    // START is sampled at edge 0; returns the edge at which DONE is first seen, or -1.
    task automatic run(input int budget, input int hold_on, input int hold_off, output int done_edge);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        done_edge = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge CLK);
            if (k == hold_on)  hold_in = 1'b1;
            if (k == hold_off) hold_in = 1'b0;
            if (done0) begin
                done_edge = k;
                break;
            end
        end
    endtask

    localparam logic [9:0] PAT_A = 10'b1011001110;
    localparam logic [9:0] PAT_B = 10'b0110100101;
    localparam logic [9:0] FLIP  = 10'b0010001000;   // bits 3 and 7

    initial begin
        int e;

        // Clean run, plus reset values and idle behaviour before START.
        reset_and_load(PAT_A, PAT_A, BN);
        check("rst_err",     int'(err0), 0);
        check("rst_done",    int'(done0), 0);
        check("rst_pass",    int'(pass0), 0);
        check("rst_timeout", int'(to0), 0);
        check("rst_re",      int'({fifo_if.FIFO_REF_RE, fifo_if.FIFO_IN_RE}), 0);
        repeat (3) @(negedge CLK);
        check("init_no_re",  ref_pulses, 0);
        run(60, -1, -1, e);
        check("clean_done_edge", e, 31);
        check("clean_err",       int'(err0), 0);
        check("clean_pass",      int'(pass0), 1);
        check("clean_pass2",     int'(pass1), 1);
        check("clean_timeout",   int'(to0), 0);
        check("clean_ref_re",    ref_pulses, 10);
        check("clean_in_re",     in_pulses, 10);
        // START in IDLE must not re-arm the checker.
        run(10, -1, -1, e);
        check("idle_restart_re", ref_pulses, 10);
        check("idle_done_held",  int'(done0), 1);
        check("idle_pass_held",  int'(pass0), 1);

        // Injected errors on bits 3 and 7.
        reset_and_load(PAT_B, PAT_B ^ FLIP, BN);
        run(60, -1, -1, e);
        check("err_done_edge", e, 31);
        check("err_count",     int'(err0), 2);
        check("err_pass_max0", int'(pass0), 0);
        check("err_count2",    int'(err1), 2);
        check("err_pass_max2", int'(pass1), 1);

        // Received FIFO held empty for 5 checks before bit 4.
        reset_and_load(PAT_A, PAT_A, BN);
        run(60, 11, 17, e);
        check("stall_done_edge", e, 36);
        check("stall_err",       int'(err0), 0);
        check("stall_pass",      int'(pass0), 1);
        check("stall_in_re",     in_pulses, 10);
        check("stall_re_viol",   re_viol, 0);

        // Received FIFO supplies only 4 bits.
        reset_and_load(PAT_A, PAT_A, 4);
`ifdef DATA_CHECKER_TIMEOUT_EN
        run(80, -1, -1, e);
        check("to_done",    int'(done0), 1);
        check("to_timeout", int'(to0), 1);
        check("to_pass",    int'(pass0), 0);
        check("to_pass2",   int'(pass1), 0);
        check("to_err",     int'(err0), 0);
        check("to_in_re",   in_pulses, 4);
        check("to_ref_re",  ref_pulses, 4);
`else
        run(80, -1, -1, e);
        check("short_done_edge", e, -1);
        check("short_done",      int'(done0), 0);
        check("short_timeout",   int'(to0), 0);
        check("short_in_re",     in_pulses, 4);
        check("short_ref_re",    ref_pulses, 4);
`endif

        // Reset after 5 bits compared (one of them mismatching), then a fresh run.
        reset_and_load(PAT_B, PAT_B ^ FLIP, BN);
        run(15, -1, -1, e);
        check("mid_err_before", int'(err0), 1);
        check("mid_in_re",      in_pulses, 5);
        RESETN = 1'b0;
        @(negedge CLK);
        RESETN = 1'b1;
        check("mid_rst_err",     int'(err0), 0);
        check("mid_rst_done",    int'(done0), 0);
        check("mid_rst_pass",    int'(pass0), 0);
        check("mid_rst_timeout", int'(to0), 0);
        repeat (5) @(negedge CLK);
        check("mid_no_re",       in_pulses, 5);
        reset_and_load(PAT_A, PAT_A, BN);
        run(60, -1, -1, e);
        check("rerun_done_edge", e, 31);
        check("rerun_err",       int'(err0), 0);
        check("rerun_pass",      int'(pass0), 1);

        check("re_on_empty", re_viol, 0);
        check("re_instances_agree", re_diff, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
